// File: rtl/nic_host_ctrl_if.sv
// Host-side packet handshakes plus NIC register bus for nic_host_ctrl.
interface nic_host_ctrl_if #(
    parameter int unsigned PACKET_WIDTH = 64
);
    logic                    tx_valid;
    logic                    tx_ready;
    logic [PACKET_WIDTH-1:0] tx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic [PACKET_WIDTH-1:0] rx_data;
    logic [1:0]              addr;
    logic [PACKET_WIDTH-1:0] d_in;
    logic [PACKET_WIDTH-1:0] d_out;
    logic                    nicEn;
    logic                    nicEnWR;
    logic [15:0]             tx_count;
    logic [15:0]             rx_count;

    // Controller side.
    modport master (
        input  tx_valid, tx_data, rx_ready, d_out,
        output tx_ready, rx_valid, rx_data, addr, d_in, nicEn, nicEnWR,
               tx_count, rx_count
    );

    // Packet source/sink and NIC side.
    modport slave (
        output tx_valid, tx_data, rx_ready, d_out,
        input  tx_ready, rx_valid, rx_data, addr, d_in, nicEn, nicEnWR,
               tx_count, rx_count
    );
endinterface

// File: rtl/nic_host_ctrl.sv
// Moves packets between one-entry host hold registers and a polled NIC.
// TX and RX share the NIC bus; contested IDLE grants alternate.
module nic_host_ctrl #(
    parameter int unsigned PACKET_WIDTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    nic_host_ctrl_if.master bus
);
    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TX_STAT = 3'd1;
    localparam logic [2:0] TX_CHK  = 3'd2;
    localparam logic [2:0] TX_WR   = 3'd3;
    localparam logic [2:0] RX_STAT = 3'd4;
    localparam logic [2:0] RX_CHK  = 3'd5;
    localparam logic [2:0] RX_RD   = 3'd6;
    localparam logic [2:0] RX_CAP  = 3'd7;

    localparam logic GRANT_TX = 1'b0;
    localparam logic GRANT_RX = 1'b1;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    logic [2:0]              state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    tx_hold_valid_q, tx_hold_valid_d;
    logic [PACKET_WIDTH-1:0] tx_hold_data_q, tx_hold_data_d;
    logic                    rx_hold_valid_q, rx_hold_valid_d;
    logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]        tx_count_q, tx_count_d;
    logic [CNT_W-1:0]        rx_count_q, rx_count_d;
    logic [1:0]              addr_q, addr_d;
    logic [PACKET_WIDTH-1:0] d_in_q, d_in_d;
    logic                    nic_en_q, nic_en_d;
    logic                    nic_en_wr_q, nic_en_wr_d;
    logic                    tx_ready_q, tx_ready_d;

    // Next state, hold registers, counters; NIC strobes decoded from the next state.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        tx_hold_valid_d = tx_hold_valid_q;
        tx_hold_data_d  = tx_hold_data_q;
        rx_hold_valid_d = rx_hold_valid_q;
        rx_data_d       = rx_data_q;
        tx_count_d      = tx_count_q;
        rx_count_d      = rx_count_q;
        addr_d          = ADDR_IN_BUF;
        d_in_d          = '0;
        nic_en_d        = 1'b0;
        nic_en_wr_d     = 1'b0;

        if (bus.tx_valid && tx_ready_q) begin
            tx_hold_valid_d = 1'b1;
            tx_hold_data_d  = bus.tx_data;
        end
        if (rx_hold_valid_q && bus.rx_ready) begin
            rx_hold_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (tx_hold_valid_q && !rx_hold_valid_q) begin
                    if (last_grant_q == GRANT_RX) begin
                        state_d      = TX_STAT;
                        last_grant_d = GRANT_TX;
                    end else begin
                        state_d      = RX_STAT;
                        last_grant_d = GRANT_RX;
                    end
                end else if (tx_hold_valid_q) begin
                    state_d = TX_STAT;
                end else if (!rx_hold_valid_q) begin
                    state_d = RX_STAT;
                end
            end
            TX_STAT: state_d = TX_CHK;
            TX_CHK:  state_d = bus.d_out[0] ? IDLE : TX_WR;
            TX_WR: begin
                tx_hold_valid_d = 1'b0;
                tx_count_d      = tx_count_q + CNT_W'(1);
                state_d         = IDLE;
            end
            RX_STAT: state_d = RX_CHK;
            RX_CHK:  state_d = bus.d_out[0] ? RX_RD : IDLE;
            RX_RD:   state_d = RX_CAP;
            RX_CAP: begin
                rx_data_d       = bus.d_out;
                rx_hold_valid_d = 1'b1;
                rx_count_d      = rx_count_q + CNT_W'(1);
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            TX_STAT: begin
                addr_d   = ADDR_IN_STAT;
                nic_en_d = 1'b1;
            end
            TX_WR: begin
                addr_d      = ADDR_IN_BUF;
                d_in_d      = tx_hold_data_q;
                nic_en_d    = 1'b1;
                nic_en_wr_d = 1'b1;
            end
            RX_STAT: begin
                addr_d   = ADDR_OUT_STAT;
                nic_en_d = 1'b1;
            end
            RX_RD: begin
                addr_d   = ADDR_OUT_BUF;
                nic_en_d = 1'b1;
            end
            default: ;
        endcase

        tx_ready_d = !tx_hold_valid_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            last_grant_q    <= GRANT_RX;
            tx_hold_valid_q <= 1'b0;
            tx_hold_data_q  <= '0;
            rx_hold_valid_q <= 1'b0;
            rx_data_q       <= '0;
            tx_count_q      <= '0;
            rx_count_q      <= '0;
            addr_q          <= ADDR_IN_BUF;
            d_in_q          <= '0;
            nic_en_q        <= 1'b0;
            nic_en_wr_q     <= 1'b0;
            tx_ready_q      <= 1'b1;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            tx_hold_valid_q <= tx_hold_valid_d;
            tx_hold_data_q  <= tx_hold_data_d;
            rx_hold_valid_q <= rx_hold_valid_d;
            rx_data_q       <= rx_data_d;
            tx_count_q      <= tx_count_d;
            rx_count_q      <= rx_count_d;
            addr_q          <= addr_d;
            d_in_q          <= d_in_d;
            nic_en_q        <= nic_en_d;
            nic_en_wr_q     <= nic_en_wr_d;
            tx_ready_q      <= tx_ready_d;
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_hold_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.addr     = addr_q;
    assign bus.d_in     = d_in_q;
    assign bus.nicEn    = nic_en_q;
    assign bus.nicEnWR  = nic_en_wr_q;
    assign bus.tx_count = tx_count_q;
    assign bus.rx_count = rx_count_q;
endmodule
